seq_match_ctrl: RTL and testbench
=================================

# seq_match_ctrl

Programmable serial-pattern detection controller that owns the bit-sequence detector datapath. It accepts a pattern configuration through a ready/valid handshake, then runs and stops the detector. While running it counts pattern matches and raises a threshold interrupt. It sits between the register/control interface and the serial input stream, replacing hard-wired fixed-pattern detectors.

## Interface
- MAX_LEN, 8: maximum pattern length in bits, range 2..16
- LEN_W, $clog2(MAX_LEN)+1: width of the length field
- CNT_W, 8: width of the match counter and the threshold
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  high only in IDLE; a write is accepted when cfg_valid and cfg_ready are both high
- cfg_pattern  in  MAX_LEN  pattern bits; bit [len-1] is the oldest bit, bit [0] the newest
- cfg_len  in  LEN_W  pattern length, legal range 1..MAX_LEN
- cfg_overlap  in  1  1: overlapping matches allowed; 0: history cleared after each match
- cfg_thresh  in  CNT_W  match count that raises irq; 0 disables the threshold
- cfg_err  out  1  one-cycle pulse when an accepted write carries an illegal cfg_len
- start  in  1  level-sampled; starts a run from IDLE
- stop  in  1  level-sampled; aborts RUN or DONE and returns to IDLE
- in_valid  in  1  in_bit is sampled this cycle
- in_bit  in  1  serial data bit
- match  out  1  one-cycle pulse per detected match
- match_cnt  out  CNT_W  matches in the current run; saturates at all-ones
- irq  out  1  sticky threshold flag
- irq_clr  in  1  clears irq
- busy  out  1  high in RUN and in DONE

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE
  - cfg_ready=1.
  - An accepted write with a legal cfg_len updates the pattern, length, overlap and threshold registers.
  - An accepted write with cfg_len of 0 or >MAX_LEN pulses cfg_err and leaves the configuration unchanged.
  - start with no write in the same cycle moves to RUN. On entry, the history register, fill count and match_cnt clear.
  - If cfg_valid and start arrive together, the write wins and start is ignored.
- RUN
  - Each cycle with in_valid=1, in_bit shifts into the history register and the fill count increments, saturating at MAX_LEN.
  - A match occurs when fill ≥ len and the last len bits equal pattern[len-1:0].
  - On a match: match pulses and match_cnt increments, saturating. With overlap=0, the fill count resets to 0.
  - If thresh≠0 and match_cnt reaches thresh on this increment, irq sets and the FSM moves to DONE.
- DONE
  - in_valid is ignored and the counter is frozen.
  - irq_clr or stop moves to IDLE.
- stop in RUN moves to IDLE. If in_valid is high in the same cycle, that bit is discarded: stop has priority.
- irq_clr in RUN or IDLE clears irq without changing state. If the set and the clear happen in the same cycle, the set wins.
- With thresh=0, the FSM never enters DONE; the counter saturates and holds.

## Timing
- Reset values:
  - FSM in IDLE.
  - cfg_ready=1, cfg_err=0, match=0, match_cnt=0, irq=0, busy=0.
  - Configuration defaults to pattern 0110, len 4, overlap 1, thresh 0.
- Reset mid-run aborts immediately. Outputs and configuration return to the reset values.
- match, match_cnt, irq and the RUN→DONE transition all update on the clock edge that samples the completing bit. They are visible the cycle after in_valid: one-cycle latency.
- cfg_err is asserted the cycle after the accepted write.
- busy and cfg_ready change on the edge that applies the state transition.
- The pattern is not re-evaluated across runs: history clears on each start.

## Structure
- Shared package seq_match_pkg holds:
  - the FSM state enum;
  - the MAX_LEN default;
  - the reset-default pattern, length, overlap and threshold constants.
- The single sub-module is seq_match_core. It contains the history shift register, the fill counter and the masked compare. Its interface is:
  - inputs: clear, shift, bit, pattern, len, overlap;
  - output: hit.
- The controller contains the FSM, the configuration registers, the counter and irq.

## Test plan
- Overlap: default configuration, start, feed 0,1,1,0,1,1,0 → match after bits 4 and 7, match_cnt=2.
- Non-overlap: overlap=0, same stream → single match after bit 4, match_cnt=1.
- Threshold: thresh=2, feed 0110 twice → irq=1 and busy=1 in DONE. Further valid bits leave match_cnt at 2. irq_clr → IDLE, busy=0.
- Illegal write: cfg_len=0 in IDLE → cfg_err pulses and the default pattern still detects 0110. A write during RUN is not accepted (cfg_ready=0).
- Abort and collisions:
  - stop with in_valid on the completing bit → no match, state IDLE.
  - cfg_valid with start → config applied, state stays IDLE.
- Reset mid-run after 3 matches → all outputs and configuration return to the reset values; the next run detects 0110.

Source files
------------

// File: rtl/seq_match_pkg.sv
// Shared types and reset defaults for the serial pattern-match controller.
package seq_match_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int          MAX_LEN_DEF = 8;
   localparam logic [15:0] DEF_PATTERN = 16'b0110;
   localparam int          DEF_LEN     = 4;
   localparam logic        DEF_OVERLAP = 1'b1;
   localparam int          DEF_THRESH  = 0;
endpackage

// File: rtl/seq_match_core.sv
// Bit-history shift register with fill tracking and length-masked pattern compare.
module seq_match_core
   import seq_match_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               shift,
   input  logic               data_bit,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic               overlap,
   output logic               hit
);
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] hist, next_hist, mask;
   logic [LEN_W-1:0]   fill, fill_inc;

   // hit looks at the history including the bit being shifted this cycle
   always_comb begin
      next_hist = {hist[MAX_LEN-2:0], data_bit};
      fill_inc  = (fill == MAX_L) ? fill : fill + LEN_W'(1);
      mask      = '0;
      for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
      hit = shift && (fill_inc >= len) && (((next_hist ^ pattern) & mask) == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
      end else if (clear) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= next_hist;
         fill <= (hit && !overlap) ? '0 : fill_inc;
      end
   end
endmodule

// File: rtl/seq_match_ctrl.sv
// Pattern-detect controller: config handshake, run/stop FSM, match counter and threshold irq.
module seq_match_ctrl
   import seq_match_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int LEN_W   = $clog2(MAX_LEN) + 1,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic [CNT_W-1:0]   cfg_thresh,
   output logic               cfg_err,
   input  logic               start,
   input  logic               stop,
   input  logic               in_valid,
   input  logic               in_bit,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               irq,
   input  logic               irq_clr,
   output logic               busy
);
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

   state_t             state;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   len;
   logic               overlap;
   logic [CNT_W-1:0]   thresh, cnt_inc;
   logic               clear, shift, hit, len_ok, irq_set;

   assign cfg_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // stop outranks in_valid, and a config write outranks start
   always_comb begin
      clear   = (state == IDLE) && start && !cfg_valid;
      shift   = (state == RUN) && in_valid && !stop;
      len_ok  = (cfg_len != '0) && (cfg_len <= MAX_L);
      cnt_inc = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
      irq_set = hit && (thresh != '0) && (cnt_inc == thresh);
   end

   seq_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .shift    (shift),
      .data_bit (in_bit),
      .pattern  (pattern),
      .len      (len),
      .overlap  (overlap),
      .hit      (hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pattern   <= DEF_PATTERN[MAX_LEN-1:0];
         len       <= LEN_W'(DEF_LEN);
         overlap   <= DEF_OVERLAP;
         thresh    <= CNT_W'(DEF_THRESH);
         cfg_err   <= 1'b0;
         match     <= 1'b0;
         match_cnt <= '0;
         irq       <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         match   <= 1'b0;
         if (irq_set) irq <= 1'b1;
         else if (irq_clr) irq <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cfg_valid) begin
                  if (len_ok) begin
                     pattern <= cfg_pattern;
                     len     <= cfg_len;
                     overlap <= cfg_overlap;
                     thresh  <= cfg_thresh;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end else if (start) begin
                  state     <= RUN;
                  match_cnt <= '0;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
               end else if (hit) begin
                  match     <= 1'b1;
                  match_cnt <= cnt_inc;
                  if (irq_set) state <= DONE;
               end
            end
            DONE: begin
               if (irq_clr || stop) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboarded bench: stimulus queues expected match counts, a negedge monitor checks each match pulse.
module tb_seq_match_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0, cfg_ready, cfg_overlap = 1'b0, cfg_err;
   logic [7:0] cfg_pattern = '0, cfg_thresh = '0, match_cnt;
   logic [3:0] cfg_len = '0;
   logic       start = 1'b0, stop = 1'b0, in_valid = 1'b0, in_bit = 1'b0;
   logic       match, irq, irq_clr = 1'b0, busy;

   int vectors = 0, errors = 0;
   logic [7:0] exp_q[$];

   seq_match_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cfg_thresh(cfg_thresh), .cfg_err(cfg_err), .start(start), .stop(stop),
      .in_valid(in_valid), .in_bit(in_bit), .match(match), .match_cnt(match_cnt),
      .irq(irq), .irq_clr(irq_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every match pulse must line up with a queued expectation
   initial begin
      forever begin
         @(negedge clk);
         if (match === 1'b1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_match: got match_cnt %0d expected no match", match_cnt);
            end else begin
               chk("match_cnt", {24'd0, match_cnt}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic send_bit(input logic b, input logic exp_m, input logic [7:0] exp_c);
      in_valid = 1'b1;
      in_bit   = b;
      if (exp_m) exp_q.push_back(exp_c);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic write_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                            input logic [7:0] th, input logic exp_err);
      cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_thresh = th;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("busy_stop", {31'd0, busy}, 32'd0);
   endtask

   task automatic drain(input string name);
      @(negedge clk);
      chk({"drain_", name}, exp_q.size(), 32'd0);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      chk("rst_cfg_err",   {31'd0, cfg_err},   32'd0);
      chk("rst_match",     {31'd0, match},     32'd0);
      chk("rst_match_cnt", {24'd0, match_cnt}, 32'd0);
      chk("rst_irq",       {31'd0, irq},       32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);

      // illegal lengths 0 and 9: error pulse for one cycle, default config intact
      write_cfg(8'hFF, 4'd0, 1'b0, 8'd5, 1'b1);
      @(negedge clk);
      chk("cfg_err_pulse", {31'd0, cfg_err}, 32'd0);
      write_cfg(8'hFF, 4'd9, 1'b0, 8'd5, 1'b1);

      // default 0110, overlap: matches after bits 4 and 7; write in RUN refused
      pulse_start();
      send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 8'd1);
      chk("run_cfg_ready", {31'd0, cfg_ready}, 32'd0);
      write_cfg(8'h03, 4'd2, 1'b1, 8'd1, 1'b0);
      send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 8'd2);
      drain("overlap");
      chk("overlap_cnt", {24'd0, match_cnt}, 32'd2);
      chk("overlap_irq", {31'd0, irq}, 32'd0);
      pulse_stop();

      // non-overlap: same stream gives a single match
      write_cfg(8'h06, 4'd4, 1'b0, 8'd0, 1'b0);
      pulse_start();
      send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 8'd1);
      send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 0, 0);
      drain("nonoverlap");
      chk("nonoverlap_cnt", {24'd0, match_cnt}, 32'd1);
      pulse_stop();

      // threshold 2: DONE with irq, further bits ignored, irq_clr returns to IDLE
      write_cfg(8'h06, 4'd4, 1'b1, 8'd2, 1'b0);
      pulse_start();
      send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 8'd1);
      send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 8'd2);
      chk("thresh_irq",  {31'd0, irq},  32'd1);
      chk("thresh_busy", {31'd0, busy}, 32'd1);
      send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 0, 0);
      drain("thresh");
      chk("done_frozen_cnt", {24'd0, match_cnt}, 32'd2);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      chk("clr_busy",      {31'd0, busy},      32'd0);
      chk("clr_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      chk("idle_irq_clr", {31'd0, irq}, 32'd0);

      // stop on the completing bit discards it
      pulse_start();
      send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0);
      stop = 1'b1;
      send_bit(0, 0, 0);
      stop = 1'b0;
      chk("stop_busy", {31'd0, busy}, 32'd0);
      drain("stop");

      // write together with start: config taken, FSM stays IDLE
      start = 1'b1;
      write_cfg(8'h05, 4'd3, 1'b1, 8'd0, 1'b0);
      start = 1'b0;
      chk("collide_busy", {31'd0, busy}, 32'd0);
      pulse_start();
      send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 1, 8'd1);
      send_bit(0, 0, 0); send_bit(1, 1, 8'd2);
      send_bit(0, 0, 0); send_bit(1, 1, 8'd3);
      drain("collide");

      // asynchronous reset mid-run restores outputs and configuration
      #1 rst = 1'b1;
      #1;
      chk("arst_cnt",       {24'd0, match_cnt}, 32'd0);
      chk("arst_busy",      {31'd0, busy},      32'd0);
      chk("arst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
      chk("arst_match",     {31'd0, match},     32'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      pulse_start();
      send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 8'd1);
      send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 1, 8'd2);
      drain("post_reset");
      chk("post_reset_busy", {31'd0, busy}, 32'd1);
      chk("post_reset_irq",  {31'd0, irq},  32'd0);
      pulse_stop();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
